// File: rtl/step_position_tracker.sv
// step_position_tracker: signed per-axis step counters with preset, snapshot, sticky overflow.
// Build option COREXY_EN: slots 0/1 report registered A+B / A-B instead of raw A/B.
module step_position_tracker #(
  parameter int N_AXES      = 4,
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [N_AXES-1:0]                           stepper_enable,
  input  logic [N_AXES-1:0]                           stepper_step,
  input  logic [N_AXES-1:0]                           stepper_direction,
  input  logic [N_AXES-1:0]                           stepper_inversion,
  input  logic                                        set_valid,
  input  logic [(N_AXES > 1 ? $clog2(N_AXES) : 1)-1:0] set_axis,
  input  logic [WIDTH-1:0]                            set_value,
  input  logic                                        snap_req,
  output logic                                        snap_valid,
  output logic [N_AXES*WIDTH-1:0]                     pos_flat,
  output logic [N_AXES*WIDTH-1:0]                     snap_flat,
  output logic [N_AXES-1:0]                           overflow,
  input  logic [N_AXES-1:0]                           ovf_clear
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CAPT = 1'b1;

  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] POS_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0][N_AXES-1:0] r_step_s;
  logic [SYNC_STAGES-1:0][N_AXES-1:0] r_dir_s;
  logic [SYNC_STAGES-1:0][N_AXES-1:0] r_en_s;
  logic [N_AXES-1:0]                  r_step_prev;
  logic [ARM_W-1:0]                   r_arm;

  logic [N_AXES-1:0][WIDTH-1:0] r_pos;
  logic [N_AXES-1:0][WIDTH-1:0] w_pos_nxt;
  logic [N_AXES-1:0][WIDTH-1:0] w_view;
  logic [N_AXES-1:0][WIDTH-1:0] r_snap;
  logic [N_AXES-1:0]            r_ovf;
  logic [N_AXES-1:0]            w_ovf_nxt;

  logic [N_AXES-1:0] w_step;
  logic [N_AXES-1:0] w_dir;
  logic [N_AXES-1:0] w_en;
  logic [N_AXES-1:0] w_edge;
  logic              w_armed;
  logic [0:0]        r_state;

  assign w_step  = r_step_s[SYNC_STAGES-1];
  assign w_dir   = r_dir_s[SYNC_STAGES-1];
  assign w_en    = r_en_s[SYNC_STAGES-1];
  assign w_armed = (r_arm == ARM_W'(ARM_MAX));
  assign w_edge  = w_step & ~r_step_prev & {N_AXES{w_armed}};

  // A STEP held high through reset reaches the last stage before arming ends
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step_s    <= '0;
      r_dir_s     <= '0;
      r_en_s      <= '0;
      r_step_prev <= '0;
      r_arm       <= '0;
    end else begin
      r_step_s    <= {r_step_s[SYNC_STAGES-2:0], stepper_step};
      r_dir_s     <= {r_dir_s[SYNC_STAGES-2:0], stepper_direction};
      r_en_s      <= {r_en_s[SYNC_STAGES-2:0], stepper_enable};
      r_step_prev <= w_step;
      r_arm       <= w_armed ? r_arm : r_arm + ARM_W'(1);
    end
  end

  always_comb begin
    w_pos_nxt = r_pos;
    w_ovf_nxt = r_ovf & ~ovf_clear;
    for (int i = 0; i < N_AXES; i++) begin
      if (set_valid && (32'(set_axis) == i)) begin
        w_pos_nxt[i] = set_value;
      end else if (w_edge[i] && !w_en[i]) begin
        if (w_dir[i] ^ stepper_inversion[i]) begin
          w_pos_nxt[i] = r_pos[i] - ONE;
          if (r_pos[i] == POS_MIN) w_ovf_nxt[i] = 1'b1;
        end else begin
          w_pos_nxt[i] = r_pos[i] + ONE;
          if (r_pos[i] == POS_MAX) w_ovf_nxt[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pos <= '0;
      r_ovf <= '0;
    end else begin
      r_pos <= w_pos_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

`ifdef COREXY_EN
  logic [WIDTH-1:0] r_cx;
  logic [WIDTH-1:0] r_cy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cx <= '0;
      r_cy <= '0;
    end else begin
      r_cx <= r_pos[0] + r_pos[1];
      r_cy <= r_pos[0] - r_pos[1];
    end
  end

  always_comb begin
    w_view    = r_pos;
    w_view[0] = r_cx;
    w_view[1] = r_cy;
  end
`else
  always_comb begin
    w_view = r_pos;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_snap  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (snap_req) begin
            r_state <= S_CAPT;
            r_snap  <= w_view;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign snap_valid = (r_state == S_CAPT);
  assign pos_flat   = w_view;
  assign snap_flat  = r_snap;
  assign overflow   = r_ovf;

endmodule
